// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: gate encodings, FSM states, hold bounds.
// Optional decoder check enabled by defining SCAN_ONEHOT_CHECK_EN.
package truth_table_scanner_pkg;

    localparam int unsigned GSEL_W = 2;
    localparam int unsigned AB_W   = 2;
    localparam int unsigned DEC_W  = 4;
    localparam int unsigned TT_W   = 4;
    localparam int unsigned HOLD_W = 4;

    localparam int unsigned HOLD_MIN = 1;
    localparam int unsigned HOLD_MAX = 15;

    localparam logic [GSEL_W-1:0] GATE_NOR  = 2'b00;
    localparam logic [GSEL_W-1:0] GATE_OR   = 2'b01;
    localparam logic [GSEL_W-1:0] GATE_AND  = 2'b10;
    localparam logic [GSEL_W-1:0] GATE_NAND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Decoder output expected for a given select.
    function automatic logic [DEC_W-1:0] ab_onehot(input logic [AB_W-1:0] ab);
        return DEC_W'(1) << ab;
    endfunction

endpackage

// File: rtl/truth_table_scanner_gate_fn_eval.sv
// Maps the decoder's one-hot response to the output of the selected 2-input gate.
module gate_fn_eval
    import truth_table_scanner_pkg::*;
(
    input  logic [GSEL_W-1:0] gate_sel_i,
    input  logic [DEC_W-1:0]  dec_y_i,
    output logic              gate_c_o
);

    // Middle decoder lines never decide a NOR/OR/AND/NAND result.
    logic unused_dec_mid;
    assign unused_dec_mid = ^dec_y_i[2:1];

    always_comb begin
        gate_c_o = 1'b0;
        unique case (gate_sel_i)
            GATE_NOR:  gate_c_o = dec_y_i[0];
            GATE_OR:   gate_c_o = ~dec_y_i[0];
            GATE_AND:  gate_c_o = dec_y_i[3];
            GATE_NAND: gate_c_o = ~dec_y_i[3];
            default:   gate_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Steps a 2-to-4 decoder select through all four combinations and records the gate truth table.
// Define SCAN_ONEHOT_CHECK_EN to flag decoder outputs that are not the expected one-hot code.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GSEL_W-1:0] gate_sel,
    output logic [AB_W-1:0]   ab,
    input  logic [DEC_W-1:0]  dec_y,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   truth_table,
    output logic              err
);

    localparam int unsigned HOLD = (HOLD_CYCLES < HOLD_MIN) ? HOLD_MIN :
                                   (HOLD_CYCLES > HOLD_MAX) ? HOLD_MAX : HOLD_CYCLES;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    state_e              state_q;
    logic [AB_W-1:0]     ab_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [GSEL_W-1:0]   gsel_q;
    logic [TT_W-1:0]     tt_q;
    logic                busy_q;
    logic                done_q;

    logic                gate_c;
    logic                accept_c;
    logic                sample_c;

    gate_fn_eval u_gate_fn_eval (
        .gate_sel_i (gsel_q),
        .dec_y_i    (dec_y),
        .gate_c_o   (gate_c)
    );

    assign accept_c = (state_q == IDLE) && start;
    assign sample_c = (state_q == SCAN) && (hold_q == HOLD_LAST);

    // Scan sequencer: select, hold counter, truth table and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ab_q    <= '0;
            hold_q  <= '0;
            gsel_q  <= GATE_NOR;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        gsel_q  <= gate_sel;
                        tt_q    <= '0;
                        ab_q    <= '0;
                        hold_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q     <= '0;
                        tt_q[ab_q] <= gate_c;
                        ab_q       <= ab_q + AB_W'(1);
                        if (ab_q == AB_W'(3)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_ONEHOT_CHECK_EN
    logic err_q;

    // Sticky: any sample with a decoder response other than 1<<ab.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept_c) begin
            err_q <= 1'b0;
        end else if (sample_c && (dec_y != ab_onehot(ab_q))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = accept_c ^ sample_c;
    assign err = 1'b0;
`endif

    assign ab          = ab_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: two scanner instances (hold 1 and hold 3), each driving a 2-to-4 decoder model.
module tb_truth_table_scanner;

`ifdef SCAN_ONEHOT_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [1:0] gs1 = 2'b00, gs3 = 2'b00;
    logic       fault1 = 1'b0, fault3 = 1'b0;
    logic [1:0] ab1, ab3;
    logic [3:0] dec1, dec3;
    logic       busy1, busy3, done1, done3, err1, err3;
    logic [3:0] tt1, tt3;

    int checks = 0;
    int errors = 0;
    int cur = 1;

    always #5 clk = ~clk;

    // 2-to-4 decoders; a fault forces 4'b0011 while the select is 1.
    assign dec1 = (fault1 && ab1 == 2'd1) ? 4'b0011 : (4'b0001 << ab1);
    assign dec3 = (fault3 && ab3 == 2'd1) ? 4'b0011 : (4'b0001 << ab3);

    truth_table_scanner #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(gs1), .ab(ab1),
        .dec_y(dec1), .busy(busy1), .done(done1), .truth_table(tt1), .err(err1));

    truth_table_scanner #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .gate_sel(gs3), .ab(ab3),
        .dec_y(dec3), .busy(busy3), .done(done3), .truth_table(tt3), .err(err3));

    logic [1:0] o_ab;
    logic       o_busy, o_done, o_err;
    logic [3:0] o_tt;
    assign o_ab   = (cur == 3) ? ab3   : ab1;
    assign o_busy = (cur == 3) ? busy3 : busy1;
    assign o_done = (cur == 3) ? done3 : done1;
    assign o_err  = (cur == 3) ? err3  : err1;
    assign o_tt   = (cur == 3) ? tt3   : tt1;

    // Reference truth table of the 2-input gate on inputs a,b with index {a,b}.
    function automatic logic [3:0] exp_tt(input logic [1:0] g);
        logic [3:0] r;
        logic [1:0] kk;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            case (g)
                2'b00:   r[k] = !(kk[1] || kk[0]);
                2'b01:   r[k] =  (kk[1] || kk[0]);
                2'b10:   r[k] =  (kk[1] && kk[0]);
                default: r[k] = !(kk[1] && kk[0]);
            endcase
        end
        return r;
    endfunction

    task automatic set_in(input int d, input logic st, input logic [1:0] g, input logic f);
        if (d == 3) begin start3 = st; gs3 = g; fault3 = f; end
        else        begin start1 = st; gs1 = g; fault1 = f; end
    endtask

    task automatic set_start(input int d, input logic st);
        if (d == 3) start3 = st; else start1 = st;
    endtask

    task automatic set_gs(input int d, input logic [1:0] g);
        if (d == 3) gs3 = g; else gs1 = g;
    endtask

    // One complete scan on instance d, checked cycle by cycle against the hold/latency rules.
    task automatic do_scan(input int d, input logic [1:0] g, input bit hold_start,
                           input bit toggle, input bit fault);
        int h;
        int n;
        logic [3:0] et;
        logic ee;
        h  = (d == 3) ? 3 : 1;
        n  = 4 * h;
        et = exp_tt(g);
        ee = fault && CHECK_ON;
        cur = d;
        @(negedge clk);
        set_in(d, 1'b1, g, fault);
        @(posedge clk); #1;
        if (!hold_start) set_start(d, 1'b0);
        for (int c = 1; c <= n + 1; c++) begin
            if (c <= n) begin
                checks++;
                if (o_busy !== 1'b1 || o_done !== 1'b0 || o_ab !== 2'((c - 1) / h)) begin
                    errors++;
                    $display("FAIL scan_cycle d=%0d g=%0d c=%0d: busy=%b done=%b ab=%0d, want busy=1 done=0 ab=%0d",
                             d, g, c, o_busy, o_done, o_ab, (c - 1) / h);
                end
                if (c == 1) begin
                    checks++;
                    if (o_tt !== 4'b0000 || o_err !== 1'b0) begin
                        errors++;
                        $display("FAIL scan_clear d=%0d: tt=%b err=%b, want tt=0000 err=0", d, o_tt, o_err);
                    end
                end
                if (toggle && c == 2) set_gs(d, ~g);
            end else begin
                checks++;
                if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ab !== 2'd0) begin
                    errors++;
                    $display("FAIL done_cycle d=%0d c=%0d: done=%b busy=%b ab=%0d, want done=1 busy=0 ab=0",
                             d, c, o_done, o_busy, o_ab);
                end
                checks++;
                if (o_tt !== et || o_err !== ee) begin
                    errors++;
                    $display("FAIL result d=%0d g=%0d: tt=%b err=%b, want tt=%b err=%b", d, g, o_tt, o_err, et, ee);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_ab !== 2'd0 || o_tt !== et || o_err !== ee) begin
            errors++;
            $display("FAIL after_done d=%0d: busy=%b done=%b ab=%0d tt=%b err=%b, want 0 0 0 %b %b",
                     d, o_busy, o_done, o_ab, o_tt, o_err, et, ee);
        end
        set_start(d, 1'b0);
        if (d == 3) fault3 = 1'b0; else fault1 = 1'b0;
    endtask

    // Idle for a number of cycles with start low and gate_sel wiggling; results must hold.
    task automatic idle_hold(input int d, input int cycles, input logic [3:0] et, input logic ee);
        cur = d;
        for (int i = 0; i < cycles; i++) begin
            set_gs(d, 2'($urandom_range(0, 3)));
            @(posedge clk); #1;
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_tt !== et || o_err !== ee || o_ab !== 2'd0) begin
            errors++;
            $display("FAIL idle_hold d=%0d: busy=%b done=%b tt=%b err=%b ab=%0d, want 0 0 %b %b 0",
                     d, o_busy, o_done, o_tt, o_err, o_ab, et, ee);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ab1, busy1, done1, tt1, err1, ab3, busy3, done3, tt3, err3} !== '0) begin
            errors++;
            $display("FAIL reset_state: dut1 ab=%0d b=%b d=%b tt=%b e=%b dut3 ab=%0d b=%b d=%b tt=%b e=%b, want all 0",
                     ab1, busy1, done1, tt1, err1, ab3, busy3, done3, tt3, err3);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_gate_sweep();
        for (int g = 0; g < 4; g++) do_scan(1, 2'(g), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold3();
        do_scan(3, 2'b00, 1'b0, 1'b0, 1'b0);
        do_scan(3, 2'b11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fault();
        do_scan(1, 2'b10, 1'b0, 1'b0, 1'b1);
        idle_hold(1, 3, exp_tt(2'b10), CHECK_ON);
        do_scan(1, 2'b10, 1'b0, 1'b0, 1'b0);
        do_scan(3, 2'b11, 1'b0, 1'b0, 1'b1);
        idle_hold(3, 2, exp_tt(2'b11), CHECK_ON);
    endtask

    task automatic test_reset_mid_scan();
        cur = 1;
        @(negedge clk);
        set_in(1, 1'b1, 2'b01, 1'b0);
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (busy1 !== 1'b1 || ab1 !== 2'd2 || tt1 !== (exp_tt(2'b01) & 4'b0011)) begin
            errors++;
            $display("FAIL mid_scan_state: busy=%b ab=%0d tt=%b, want busy=1 ab=2 tt=%b",
                     busy1, ab1, tt1, exp_tt(2'b01) & 4'b0011);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ab1, busy1, done1, tt1, err1} !== '0) begin
            errors++;
            $display("FAIL async_reset: ab=%0d busy=%b done=%b tt=%b err=%b, want all 0", ab1, busy1, done1, tt1, err1);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_scan(1, 2'b01, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_scan(1, 2'b10, 1'b1, 1'b1, 1'b0);
        do_scan(1, 2'b00, 1'b1, 1'b1, 1'b0);
        do_scan(3, 2'b01, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int d;
        logic [1:0] g;
        bit f;
        for (int i = 0; i < 24; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 3 : 1;
            g = 2'($urandom_range(0, 3));
            f = (g[1] == 1'b1) && ($urandom_range(0, 2) == 0);
            do_scan(d, g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f);
            idle_hold(d, $urandom_range(0, 3), exp_tt(g), f && CHECK_ON);
        end
    endtask

    initial begin
        test_reset();
        test_gate_sweep();
        test_hold3();
        test_fault();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter: HOLD_CYCLES, default 1, number of cycles (1..15) each input combination is held before sampling.
REQ-002 Port: clk  input  1  rising-edge clock; one clock domain.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a full scan; sampled only in IDLE.
REQ-005 Port: gate_sel  input  2  gate function under test: 00 NOR, 01 OR, 10 AND, 11 NAND.
REQ-006 Port: ab  output  2  combination driven to the downstream 2-to-4 decoder select, {a,b}.
REQ-007 Port: dec_y  input  4  one-hot decoder output returned combinationally for the current ab.
REQ-008 Port: busy  output  1  high while a scan is in progress.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: truth_table  output  4  bit k = gate output for ab==k.
REQ-011 Port: err  output  1  sticky flag: decoder output was not one-hot at a sample point.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE.
REQ-013 IDLE with start=1 SHALL latch gate_sel, clear truth_table and err, set ab=0 and the hold counter to 0, and go to SCAN.
REQ-014 IDLE with start=0 SHALL hold all outputs.
REQ-015 In SCAN, ab SHALL hold each value for exactly HOLD_CYCLES cycles.
REQ-016 The sample SHALL be taken in the last hold cycle.
REQ-017 The gate value from the REQ-018 mapping SHALL be written to truth_table[ab].
REQ-018 Gate mapping: NOR=dec_y[0]; OR=~dec_y[0]; AND=dec_y[3]; NAND=~dec_y[3].
REQ-019 After the sample, ab SHALL increment by one.
REQ-020 The sample at ab==3 SHALL go to DONE, and ab SHALL return to 0.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-022 done SHALL be 1 only in DONE.
REQ-023 busy SHALL be 1 only in SCAN.
REQ-024 Latency: with start sampled at edge 0, done SHALL be high in cycle 4*HOLD_CYCLES+1.
REQ-025 start SHALL be ignored in SCAN and DONE; gate_sel changes during a scan SHALL have no effect.
REQ-026 truth_table and err SHALL hold after DONE until the next accepted start.
REQ-027 ab SHALL be registered with no glitch between combinations; dec_y is used only at sample points.

Reset
REQ-028 rst_n low, at any time including mid-scan, SHALL immediately force IDLE, ab=0, busy=0, done=0, truth_table=0, err=0, hold counter=0 and latched gate_sel=00.
REQ-029 After rst_n rises, the first start SHALL be accepted on the first clk edge.

Configuration
REQ-030 Macro SCAN_ONEHOT_CHECK_EN defined: at each sample, err SHALL be set if dec_y is not exactly one-hot or dec_y != (1<<ab).
REQ-031 Macro SCAN_ONEHOT_CHECK_EN defined: err, once set, SHALL remain set until reset or the next accepted start.
REQ-032 Macro SCAN_ONEHOT_CHECK_EN undefined: err SHALL be constant 0 and the check logic SHALL be absent.

Structure
REQ-033 A shared package SHALL hold: the gate_sel encoding constants (GATE_NOR, GATE_OR, GATE_AND, GATE_NAND), the FSM state typedef, and the HOLD_CYCLES bounds.
REQ-034 One combinational sub-module, gate_fn_eval, SHALL map (gate_sel, dec_y) to the gate bit.
REQ-035 The FSM, counters and registers SHALL live in truth_table_scanner.
REQ-036 The bench SHALL connect ab to the existing 2-to-4 decoder, with dec_y taken from its outputs.

Verification
REQ-037 HOLD=1, gate_sel=00, start pulse -> ab steps 0,1,2,3 in cycles 1-4; done high in cycle 5; truth_table=4'b0001; err=0.
REQ-038 HOLD=1, gate_sel sweep 01/10/11 -> truth_table=4'b1110 / 4'b1000 / 4'b0111 respectively.
REQ-039 HOLD=3, gate_sel=00 -> each ab held 3 cycles; done high in cycle 13; truth_table=4'b0001.
REQ-040 Macro on: force dec_y=4'b0011 while ab==1 -> err=1 at DONE and remains 1; next start clears it.
REQ-041 Macro off: same fault -> err=0.
REQ-042 rst_n low during cycle 3 of a scan -> all outputs 0 asynchronously; start after release -> full, correct scan.
REQ-043 start held high throughout a scan, with gate_sel toggled mid-scan -> exactly one done pulse per scan; truth_table matches the gate_sel latched at start.
